// File: rtl/iter_shifter_if.sv
// iter_shifter_if: request/response bundle for the iterative shift unit.
//   in_valid/in_ready     request handshake (requester -> shifter)
//   in_A, in_B            operand and unsigned shift amount
//   in_Shiftop            00 SLL, 11 SRL, 10 SRA, 01 rotate right or zero-op
//   out_valid/out_ready   response handshake (shifter -> consumer)
//   out_Result            shifted result, qualified by out_valid
// Modports: master = requester/consumer side, slave = shifter side.
interface iter_shifter_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                          in_valid;
    logic                          in_ready;
    logic [DATA_WIDTH-1:0]         in_A;
    logic [$clog2(DATA_WIDTH)-1:0] in_B;
    logic [1:0]                    in_Shiftop;
    logic                          out_valid;
    logic                          out_ready;
    logic [DATA_WIDTH-1:0]         out_Result;

    modport master (
        output in_valid, in_A, in_B, in_Shiftop, out_ready,
        input  in_ready, out_valid, out_Result
    );

    modport slave (
        input  in_valid, in_A, in_B, in_Shiftop, out_ready,
        output in_ready, out_valid, out_Result
    );
endinterface

// File: rtl/iter_shifter.sv
// iter_shifter: multi-cycle handshaked shift unit. Accepts one operand /
// shift-amount / op triple, shifts BITS_PER_CYCLE positions per clock and
// returns the result over a valid/ready response port.
// Ports:
//   clk     rising-edge clock
//   resetn  synchronous active-low reset
//   bus     iter_shifter_if.slave (request and response handshakes)
// Parameters:
//   DATA_WIDTH      operand/result width (power of two, >= 8)
//   BITS_PER_CYCLE  positions shifted per SHIFT cycle (power of two, 1..DATA_WIDTH/2)
// Build option:
//   ITER_SHIFTER_ROTATE_EN  when defined, Shiftop 01 rotates right; otherwise
//                           Shiftop 01 is a zero-op returning 0 after one edge.
module iter_shifter #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input logic           clk,
    input logic           resetn,
    iter_shifter_if.slave bus
);
    localparam int unsigned CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] STEP = CW'(BITS_PER_CYCLE);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_ROT = 2'b01,
        OP_SRA = 2'b10,
        OP_SRL = 2'b11
    } op_t;

    state_t                state, state_nx;
    op_t                   op;
    logic [DATA_WIDTH-1:0] data;
    logic [DATA_WIDTH-1:0] shifted;
    logic [CW-1:0]         count;
    logic [CW-1:0]         step;
    logic                  zero_op;
    logic                  accept;

`ifdef ITER_SHIFTER_ROTATE_EN
    logic [2*DATA_WIDTH-1:0] rot;
`endif

    always_comb begin
`ifdef ITER_SHIFTER_ROTATE_EN
        zero_op = 1'b0;
`else
        zero_op = (bus.in_Shiftop == OP_ROT);
`endif
    end

    assign accept = (state == S_IDLE) && bus.in_valid;

    // Final partial step: never shift past the remaining count.
    always_comb begin
        step = (count < STEP) ? count : STEP;
    end

    always_comb begin
        shifted = data;
`ifdef ITER_SHIFTER_ROTATE_EN
        rot = {data, data} >> step;
`endif
        case (op)
            OP_SLL: shifted = data << step;
            OP_SRL: shifted = data >> step;
            // Sign bit of data is the latched A's sign throughout the shift.
            OP_SRA: shifted = $unsigned($signed(data) >>> step);
`ifdef ITER_SHIFTER_ROTATE_EN
            OP_ROT: shifted = rot[DATA_WIDTH-1:0];
`endif
            default: shifted = data;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx      = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (state)
            S_IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    state_nx = (bus.in_B == '0 || zero_op) ? S_DONE : S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (count <= STEP) begin
                    state_nx = S_DONE;
                end
            end
            S_DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            data  <= '0;
            count <= '0;
            op    <= OP_SLL;
        end else if (accept) begin
            data  <= zero_op ? '0 : bus.in_A;
            count <= bus.in_B;
            op    <= op_t'(bus.in_Shiftop);
        end else if (state == S_SHIFT) begin
            data  <= shifted;
            count <= count - step;
        end
    end

    assign bus.out_Result = data;
endmodule

// File: tb/tb_iter_shifter.sv
// tb_iter_shifter: directed and randomized self-checking bench for iter_shifter.
// Two instances share stimulus: u_s1 (BITS_PER_CYCLE=1) and u_s4 (BITS_PER_CYCLE=4);
// `sel` picks which one receives in_valid and whose outputs are observed.
// Expectations for Shiftop 01 follow ITER_SHIFTER_ROTATE_EN as defined for the build.
module tb_iter_shifter;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        sel = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_A = '0;
    logic [4:0]  in_B = '0;
    logic [1:0]  in_Shiftop = '0;
    logic        out_ready = 1'b0;

    logic        in_ready_m;
    logic        out_valid_m;
    logic [31:0] out_Result_m;

    int nchk = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    iter_shifter_if #(.DATA_WIDTH(32)) b1 ();
    iter_shifter_if #(.DATA_WIDTH(32)) b4 ();

    assign b1.in_valid   = in_valid & ~sel;
    assign b1.in_A       = in_A;
    assign b1.in_B       = in_B;
    assign b1.in_Shiftop = in_Shiftop;
    assign b1.out_ready  = out_ready;
    assign b4.in_valid   = in_valid & sel;
    assign b4.in_A       = in_A;
    assign b4.in_B       = in_B;
    assign b4.in_Shiftop = in_Shiftop;
    assign b4.out_ready  = out_ready;

    assign in_ready_m   = sel ? b4.in_ready   : b1.in_ready;
    assign out_valid_m  = sel ? b4.out_valid  : b1.out_valid;
    assign out_Result_m = sel ? b4.out_Result : b1.out_Result;

    iter_shifter #(.DATA_WIDTH(32), .BITS_PER_CYCLE(1)) u_s1 (
        .clk(clk), .resetn(resetn), .bus(b1)
    );
    iter_shifter #(.DATA_WIDTH(32), .BITS_PER_CYCLE(4)) u_s4 (
        .clk(clk), .resetn(resetn), .bus(b4)
    );

    function automatic logic [31:0] model(input logic [31:0] a, input logic [4:0] b,
                                          input logic [1:0] op);
        case (op)
            2'b00:   model = a << b;
            2'b11:   model = a >> b;
            2'b10:   model = $unsigned($signed(a) >>> b);
`ifdef ITER_SHIFTER_ROTATE_EN
            default: model = (a >> b) | (a << (6'd32 - {1'b0, b}));
`else
            default: model = '0;
`endif
        endcase
    endfunction

    function automatic int exp_latency(input logic [4:0] b, input logic [1:0] op,
                                       input int step);
`ifndef ITER_SHIFTER_ROTATE_EN
        if (op == 2'b01) return 1;
`endif
        return (int'(b) + step - 1) / step + 1;
    endfunction

    task automatic run_op(input logic s, input logic [31:0] a, input logic [4:0] b,
                          input logic [1:0] op, input logic [31:0] exp_res,
                          input int exp_lat, input int pre, input int stall,
                          input string name);
        int guard;
        int lat;
        @(negedge clk);
        sel = s;
        repeat (pre) @(negedge clk);
        in_A = a; in_B = b; in_Shiftop = op; in_valid = 1'b1;
        guard = 0;
        while (in_ready_m !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        nchk++;
        if (in_ready_m !== 1'b1) begin
            nfail++;
            $display("FAIL %s accept: in_ready=%b required 1", name, in_ready_m);
            in_valid = 1'b0;
            return;
        end
        @(negedge clk);
        // Scramble inputs after the accepting edge; they must not matter.
        in_valid = 1'b0; in_A = ~a; in_B = ~b; in_Shiftop = ~op;
        lat = 1;
        while (out_valid_m !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        nchk++;
        if (lat != exp_lat) begin
            nfail++;
            $display("FAIL %s latency: got %0d required %0d", name, lat, exp_lat);
        end
        nchk++;
        if (out_Result_m !== exp_res) begin
            nfail++;
            $display("FAIL %s result: got %h required %h", name, out_Result_m, exp_res);
        end
        repeat (stall) @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        nchk++;
        if (in_ready_m !== 1'b1 || out_valid_m !== 1'b0) begin
            nfail++;
            $display("FAIL %s release: in_ready=%b out_valid=%b required 1/0",
                     name, in_ready_m, out_valid_m);
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        nchk++;
        if (in_ready_m !== 1'b1) begin
            nfail++; $display("FAIL reset in_ready: got %b required 1", in_ready_m);
        end
        nchk++;
        if (out_valid_m !== 1'b0) begin
            nfail++; $display("FAIL reset out_valid: got %b required 0", out_valid_m);
        end
        nchk++;
        if (out_Result_m !== 32'h0) begin
            nfail++; $display("FAIL reset out_Result: got %h required 0", out_Result_m);
        end
        resetn = 1'b1;
    endtask

    task automatic test_shifts();
        run_op(0, 32'h0000_0001, 5'd31, 2'b00, 32'h8000_0000, 32, 0, 0, "sll31_s1");
        run_op(0, 32'h8000_00F0, 5'd4,  2'b10, 32'hF800_000F, 5,  0, 0, "sra4_s1");
        run_op(0, 32'h8000_00F0, 5'd4,  2'b11, 32'h0800_000F, 5,  0, 0, "srl4_s1");
        run_op(1, 32'h8000_00F0, 5'd4,  2'b10, 32'hF800_000F, 2,  0, 0, "sra4_s4");
        run_op(1, 32'h8000_0000, 5'd31, 2'b10, 32'hFFFF_FFFF, 9,  0, 0, "sra31_s4");
        run_op(1, 32'h1234_5678, 5'd7,  2'b00, 32'h1A2B_3C00, 3,  0, 0, "sll7_s4");
        run_op(1, 32'hFFFF_FFFF, 5'd31, 2'b11, 32'h0000_0001, 9,  0, 0, "srl31_s4");
    endtask

    task automatic test_zero_and_rotate();
        run_op(0, 32'hDEAD_BEEF, 5'd0, 2'b00, 32'hDEAD_BEEF, 1, 0, 0, "b0_sll");
        run_op(0, 32'hDEAD_BEEF, 5'd0, 2'b11, 32'hDEAD_BEEF, 1, 0, 0, "b0_srl");
        run_op(1, 32'hDEAD_BEEF, 5'd0, 2'b10, 32'hDEAD_BEEF, 1, 0, 0, "b0_sra");
`ifdef ITER_SHIFTER_ROTATE_EN
        run_op(0, 32'hDEAD_BEEF, 5'd0, 2'b01, 32'hDEAD_BEEF, 1, 0, 0, "b0_rot");
        run_op(0, 32'h0000_0001, 5'd1, 2'b01, 32'h8000_0000, 2, 0, 0, "ror1_s1");
        run_op(1, 32'h0000_00F1, 5'd5, 2'b01, 32'h8800_0007, 3, 0, 0, "ror5_s4");
`else
        run_op(0, 32'hDEAD_BEEF, 5'd0,  2'b01, 32'h0, 1, 0, 0, "b0_zeroop");
        run_op(0, 32'h0000_0001, 5'd1,  2'b01, 32'h0, 1, 0, 0, "zeroop_b1");
        run_op(1, 32'hFFFF_FFFF, 5'd20, 2'b01, 32'h0, 1, 0, 0, "zeroop_b20_s4");
`endif
    endtask

    task automatic test_backpressure();
        int guard;
        int bad;
        @(negedge clk);
        sel = 1'b0;
        in_A = 32'h0000_0003; in_B = 5'd2; in_Shiftop = 2'b00; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        guard = 0;
        while (out_valid_m !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        // A competing request is offered while the result is held.
        in_A = 32'hAAAA_AAAA; in_B = 5'd0; in_Shiftop = 2'b00; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            nchk++;
            if (out_valid_m !== 1'b1 || out_Result_m !== 32'h0000_000C || in_ready_m !== 1'b0) begin
                nfail++;
                $display("FAIL hold cycle %0d: valid=%b result=%h ready=%b required 1/0000000c/0",
                         i, out_valid_m, out_Result_m, in_ready_m);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        nchk++;
        if (in_ready_m !== 1'b1 || out_valid_m !== 1'b0) begin
            nfail++;
            $display("FAIL hold release: in_ready=%b out_valid=%b required 1/0",
                     in_ready_m, out_valid_m);
        end
        bad = 0;
        repeat (4) begin
            @(negedge clk);
            if (out_valid_m !== 1'b0) bad++;
        end
        nchk++;
        if (bad != 0) begin
            nfail++; $display("FAIL hold ignored_req: %0d valid cycles required 0", bad);
        end
    endtask

    task automatic test_reset_mid_shift();
        int stale;
        @(negedge clk);
        sel = 1'b0;
        in_A = 32'hFFFF_0000; in_B = 5'd20; in_Shiftop = 2'b11; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        nchk++;
        if (in_ready_m !== 1'b0 || out_valid_m !== 1'b0) begin
            nfail++;
            $display("FAIL midshift busy: in_ready=%b out_valid=%b required 0/0",
                     in_ready_m, out_valid_m);
        end
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        nchk++;
        if (in_ready_m !== 1'b1 || out_valid_m !== 1'b0 || out_Result_m !== 32'h0) begin
            nfail++;
            $display("FAIL midshift reset: ready=%b valid=%b result=%h required 1/0/00000000",
                     in_ready_m, out_valid_m, out_Result_m);
        end
        stale = 0;
        repeat (30) begin
            @(negedge clk);
            if (out_valid_m !== 1'b0) stale++;
        end
        nchk++;
        if (stale != 0) begin
            nfail++; $display("FAIL midshift stale: %0d valid cycles required 0", stale);
        end
        run_op(0, 32'h0000_00F0, 5'd4, 2'b11, 32'h0000_000F, 5, 0, 0, "after_reset");
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [4:0]  b;
        logic [1:0]  op;
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 20; i++) begin
                a  = $urandom;
                b  = 5'($urandom_range(0, 31));
                op = 2'($urandom_range(0, 3));
                run_op(s[0], a, b, op, model(a, b, op),
                       exp_latency(b, op, (s == 0) ? 1 : 4),
                       $urandom_range(0, 2), $urandom_range(0, 3),
                       (s == 0) ? "rand_s1" : "rand_s4");
            end
        end
    endtask

    initial begin
        test_reset();
        test_shifts();
        test_zero_and_rotate();
        test_backpressure();
        test_reset_mid_shift();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
